// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: funct3 codes, FSM state encoding and width-legality helpers for the MEM stage
package mem_stage_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic {IDLE = 1'b0, RMW = 1'b1} state_t;
  function automatic logic load_f3_ok(input logic [2:0] f);
    return f inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction
  function automatic logic store_f3_ok(input logic [2:0] f);
    return f inside {F3_SB, F3_SH, F3_SW};
  endfunction
endpackage

// File: rtl/mem_stage_lsu_load_ext.sv
// mem_stage_lsu_load_ext: sign/zero-extends a data_mem word per load funct3 (funct3, word -> result)
module mem_stage_lsu_load_ext
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);
  always_comb begin
    result = funct3 == F3_LB  ? {{24{word[7]}}, word[7:0]} :
             funct3 == F3_LBU ? {24'b0, word[7:0]} :
             funct3 == F3_LH  ? {{16{word[15]}}, word[15:0]} :
             funct3 == F3_LHU ? {16'b0, word[15:0]} : word;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage driving data_mem (ce/we/addr/data_i), 2-cycle RMW for SB/SH, registered MEM/WB (wb_*), stall upstream
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_alu_result,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_i,
  input  logic [31:0] mem_data_o,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        wb_fault
);
  state_t state, state_n;
  logic [31:0] old_q, addr_q, sd_q, ext;
  logic [2:0] f3_q;
  logic [4:0] rd_q;
  logic idle, is_mem, fault, ok_load, ok_store, sub_word;
  mem_stage_lsu_load_ext u_ext (.funct3(ex_funct3), .word(mem_data_o), .result(ext));
  always_comb begin
    idle     = state == IDLE;
    is_mem   = ex_mem_read | ex_mem_write;
    // data_mem touches addr..addr+3, so the last legal base is MEM_BYTES-4 for every width
    fault    = idle & ex_valid & is_mem & ((ex_mem_read & ex_mem_write) |
               (ex_mem_read & !load_f3_ok(ex_funct3)) | (ex_mem_write & !store_f3_ok(ex_funct3)) |
               (ex_addr > 32'(MEM_BYTES - 4)));
    ok_load  = idle & ex_valid & ex_mem_read & !fault;
    ok_store = idle & ex_valid & ex_mem_write & !fault;
    sub_word = ok_store & (ex_funct3 != F3_SW);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (idle & sub_word) ? RMW : IDLE;
  end
  always_comb begin
    mem_ce     = !rst & (!idle | ok_load | ok_store);
    mem_we     = !rst & (!idle | (ok_store & !sub_word));
    mem_addr   = idle ? ex_addr : addr_q;
    mem_data_i = idle ? ex_store_data :
                 f3_q == F3_SB ? {old_q[31:8], sd_q[7:0]} : {old_q[31:16], sd_q[15:0]};
    stall      = !rst & sub_word;
  end
  always_ff @(posedge clk) begin
    if (idle & sub_word) begin
      old_q  <= mem_data_o;
      addr_q <= ex_addr;
      sd_q   <= ex_store_data;
      f3_q   <= ex_funct3;
      rd_q   <= ex_rd;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      wb_fault     <= 1'b0;
    end else if (!idle) begin
      wb_valid     <= 1'b1;
      wb_rd        <= rd_q;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      wb_fault     <= 1'b0;
    end else if (!ex_valid || sub_word) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid     <= 1'b1;
      wb_rd        <= ex_rd;
      wb_fault     <= fault;
      wb_reg_write <= (ok_load | !is_mem) & ex_reg_write;
      wb_data      <= ok_load ? ext : is_mem ? 32'b0 : ex_alu_result;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed vectors against a byte-array data_mem model with hand-computed expectations
module tb_mem_stage_lsu;
  logic clk = 0, rst = 1;
  logic ex_valid = 0, ex_mem_read = 0, ex_mem_write = 0, ex_reg_write = 0;
  logic [2:0] ex_funct3 = 0;
  logic [31:0] ex_addr = 0, ex_store_data = 0, ex_alu_result = 0;
  logic [4:0] ex_rd = 0;
  logic mem_ce, mem_we, stall, wb_valid, wb_reg_write, wb_fault;
  logic [31:0] mem_addr, mem_data_i, mem_data_o, wb_data;
  logic [4:0] wb_rd;
  logic [7:0] mem [0:1023];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_stage_lsu #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .ex_alu_result(ex_alu_result), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data), .wb_fault(wb_fault)
  );
  function automatic logic [31:0] word_at(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction
  always_comb begin
    mem_data_o = (mem_addr <= 32'd1020) ? word_at(int'(mem_addr[9:0])) : 32'h0;
  end
  always @(posedge clk) begin
    if (mem_ce && mem_we && mem_addr <= 32'd1020) begin
      mem[mem_addr[9:0]]        <= mem_data_i[7:0];
      mem[mem_addr[9:0] + 10'd1] <= mem_data_i[15:8];
      mem[mem_addr[9:0] + 10'd2] <= mem_data_i[23:16];
      mem[mem_addr[9:0] + 10'd3] <= mem_data_i[31:24];
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                       input logic [4:0] rd, input logic rw);
    @(negedge clk);
    ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_funct3 = f; ex_addr = a;
    ex_store_data = sd; ex_alu_result = alu; ex_rd = rd; ex_reg_write = rw;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_word(input int a, input logic [31:0] d);
    {mem[a+3], mem[a+2], mem[a+1], mem[a]} = d;
  endtask
  task automatic load(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
    drive(1, 1, 0, f, a, 0, 0, 5'd1, 1);
    check({tag, "_ce"}, mem_ce, 1);
    check({tag, "_stall"}, stall, 0);
    tick();
    check({tag, "_data"}, wb_data, exp);
    check({tag, "_fault"}, wb_fault, 0);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h80; mem[1] = 8'h7F; mem[2] = 8'h01; mem[3] = 8'hFF;
    set_word(16, 32'h11223344);
    set_word(32, 32'h55667788);
    set_word(32'h3FC, 32'hDEADBEEF);
    drive(1, 1, 0, 3'b010, 0, 0, 0, 5'd3, 1);
    check("rst_ce", mem_ce, 0);
    check("rst_stall", stall, 0);
    tick(); tick();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_rw", wb_reg_write, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_fault", wb_fault, 0);
    rst = 0;
    load("lb", 3'b000, 0, 32'hFFFFFF80);
    check("lb_valid", wb_valid, 1);
    check("lb_rw", wb_reg_write, 1);
    check("lb_rd", wb_rd, 1);
    load("lbu", 3'b100, 0, 32'h00000080);
    load("lh", 3'b001, 0, 32'h00007F80);
    load("lhu", 3'b101, 2, 32'h0000FF01);
    load("lh_neg", 3'b001, 2, 32'hFFFFFF01);
    load("lw", 3'b010, 0, 32'hFF017F80);
    drive(1, 0, 1, 3'b000, 32'h10, 32'hAABBCCEE, 0, 5'd7, 0);
    check("sb1_ce", mem_ce, 1);
    check("sb1_we", mem_we, 0);
    check("sb1_stall", stall, 1);
    tick();
    check("sb1_bubble", wb_valid, 0);
    check("sb2_ce", mem_ce, 1);
    check("sb2_we", mem_we, 1);
    check("sb2_stall", stall, 0);
    check("sb2_addr", mem_addr, 32'h10);
    check("sb2_data_i", mem_data_i, 32'h112233EE);
    tick();
    check("sb2_valid", wb_valid, 1);
    check("sb2_rw", wb_reg_write, 0);
    check("sb_mem", word_at(16), 32'h112233EE);
    set_word(16, 32'h11223344);
    drive(1, 0, 1, 3'b001, 32'h10, 32'h0000BEEF, 0, 5'd7, 0);
    check("sh1_stall", stall, 1);
    tick();
    check("sh2_data_i", mem_data_i, 32'h1122BEEF);
    tick();
    load("sh_readback", 3'b010, 32'h10, 32'h1122BEEF);
    drive(1, 1, 0, 3'b010, 32'h3FD, 0, 0, 5'd9, 1);
    check("oob_ce", mem_ce, 0);
    tick();
    check("oob_valid", wb_valid, 1);
    check("oob_fault", wb_fault, 1);
    check("oob_rw", wb_reg_write, 0);
    check("oob_data", wb_data, 0);
    check("oob_rd", wb_rd, 9);
    load("lw_top", 3'b010, 32'h3FC, 32'hDEADBEEF);
    drive(1, 0, 1, 3'b100, 32'h20, 32'h1, 0, 5'd2, 0);
    check("badf3_ce", mem_ce, 0);
    check("badf3_stall", stall, 0);
    tick();
    check("badf3_fault", wb_fault, 1);
    drive(1, 1, 1, 3'b010, 32'h20, 32'h1, 0, 5'd2, 1);
    check("rw_both_ce", mem_ce, 0);
    tick();
    check("rw_both_fault", wb_fault, 1);
    check("badf3_mem", word_at(32), 32'h55667788);
    drive(1, 0, 0, 3'b000, 0, 0, 32'h1234, 5'd5, 1);
    check("alu_ce", mem_ce, 0);
    tick();
    check("alu_data", wb_data, 32'h00001234);
    check("alu_rd", wb_rd, 5);
    check("alu_rw", wb_reg_write, 1);
    check("alu_fault", wb_fault, 0);
    drive(0, 0, 0, 3'b000, 0, 0, 32'h9999, 5'd6, 1);
    check("nop_ce", mem_ce, 0);
    tick();
    check("nop_valid", wb_valid, 0);
    check("nop_rw", wb_reg_write, 0);
    check("nop_hold_data", wb_data, 32'h00001234);
    check("nop_hold_rd", wb_rd, 5);
    drive(1, 0, 1, 3'b000, 32'h20, 32'h000000AB, 0, 5'd4, 0);
    check("rmwrst1_stall", stall, 1);
    tick();
    rst = 1;
    #1;
    check("rmwrst_ce", mem_ce, 0);
    check("rmwrst_we", mem_we, 0);
    tick();
    check("rmwrst_valid", wb_valid, 0);
    check("rmwrst_data", wb_data, 0);
    check("rmwrst_rd", wb_rd, 0);
    check("rmwrst_mem", word_at(32), 32'h55667788);
    rst = 0;
    drive(1, 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 5'd4, 0);
    check("sw_ce", mem_ce, 1);
    check("sw_we", mem_we, 1);
    check("sw_stall", stall, 0);
    check("sw_data_i", mem_data_i, 32'hCAFEF00D);
    tick();
    check("sw_valid", wb_valid, 1);
    check("sw_rw", wb_reg_write, 0);
    check("sw_mem", word_at(32), 32'hCAFEF00D);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Pipeline MEM stage that sits directly upstream of data_mem.
- Takes EX/MEM operands and drives data_mem's ce/we/addr/data_i.
- Sign- or zero-extends load data and registers the MEM/WB result.
- data_mem always writes 4 bytes, so SB/SH become a 2-cycle read-modify-write. The block stalls upstream for that extra cycle.

Parameters:
MEM_BYTES, 1024, size of the data_mem byte array; bound for the range check.

Ports:
clk  in  1  clock
rst  in  1  reset
ex_valid  in  1  EX/MEM slot holds an instruction
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_funct3  in  3  RV32I width code: LB/LH/LW/LBU/LHU, SB/SH/SW
ex_addr  in  32  effective byte address
ex_store_data  in  32  rs2 value
ex_alu_result  in  32  result for non-memory instructions
ex_rd  in  5  destination register
ex_reg_write  in  1  writes rd
mem_ce  out  1  to data_mem ce
mem_we  out  1  to data_mem we
mem_addr  out  32  to data_mem addr
mem_data_i  out  32  to data_mem data_i
mem_data_o  in  32  from data_mem data_o (combinational read)
stall  out  1  upstream must hold EX/MEM inputs this cycle
wb_valid  out  1  MEM/WB slot valid
wb_rd  out  5  MEM/WB destination
wb_reg_write  out  1  MEM/WB write enable
wb_data  out  32  MEM/WB write data
wb_fault  out  1  access was rejected

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- On reset:
  - state = IDLE.
  - wb_valid, wb_rd, wb_reg_write, wb_data, wb_fault all 0.
  - mem_ce, mem_we, stall are 0 while rst is high.
- mem_* and stall are combinational from state and the current or latched inputs. wb_* are registered at posedge clk.
- Fault check, IDLE state, ex_valid=1 and a memory op; any of these is a fault:
  - ex_mem_read and ex_mem_write both set;
  - funct3 illegal for the direction;
  - ex_addr > MEM_BYTES-4, for all widths, because data_mem touches addr..addr+3.
- Fault response: mem_ce=0. Next edge: wb_valid=1, wb_fault=1, wb_reg_write=0, wb_data=0, wb_rd=ex_rd.
- IDLE, non-memory valid op: next edge loads wb_* with wb_data=ex_alu_result, wb_fault=0. Latency 1.
- IDLE, load:
  - mem_ce=1, mem_we=0, mem_addr=ex_addr.
  - Next edge: wb_data = extend(mem_data_o).
    - LB: sign-extend [7:0].
    - LBU: zero-extend [7:0].
    - LH: sign-extend [15:0].
    - LHU: zero-extend [15:0].
    - LW: all 32 bits.
  - Latency 1, no stall.
- IDLE, SW: mem_ce=1, mem_we=1, mem_data_i=ex_store_data. Next edge: wb_valid=1, wb_reg_write=0. Latency 1.
- IDLE, SB/SH (first cycle):
  - mem_ce=1, mem_we=0, stall=1.
  - Edge: latch old=mem_data_o, plus addr, store data, funct3, rd.
  - wb_valid <= 0 (bubble). Go to RMW.
- RMW state (second cycle):
  - mem_ce=1, mem_we=1, mem_addr=latched addr, stall=0.
  - mem_data_i: SB = {old[31:8], sd[7:0]}; SH = {old[31:16], sd[15:0]}.
  - Edge: wb_valid=1, wb_reg_write=0. Return to IDLE.
- ex_valid=0 in IDLE: mem_ce=0. Next edge: wb_valid=0, wb_reg_write=0; other wb_* hold.
- rst during RMW: the write is suppressed (mem_ce=0 that cycle), state -> IDLE, wb_* cleared.
- Only latched values are used in RMW. Upstream holds its inputs anyway because stall was high.

Decomposition:
- Shared package (mem_stage_pkg):
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, F3_SB=000, F3_SH=001, F3_SW=010.
  - State encoding IDLE=0, RMW=1.
- One natural sub-module: load_ext (combinational funct3 + 32-bit word -> extended 32-bit result). The top module holds the FSM, range check and MEM/WB registers.

Test Plan:
- Memory bytes 0..3 = 80 7F 01 FF. LB addr 0 -> wb_data=FFFFFF80. LBU -> 00000080. LH -> 00007F80. LW -> FF017F80. Each is 1 cycle with stall=0.
- Word at 0x10 = 11223344. SB addr 0x10, data 0xAABBCCEE:
  - Cycle 1: ce=1, we=0, stall=1, wb_valid drops to 0.
  - Cycle 2: we=1, mem_data_i=112233EE.
  - Memory then holds 112233EE.
- Same preset, SH addr 0x10, data 0x0000BEEF -> mem_data_i=1122BEEF; word reads back 1122BEEF.
- LW addr MEM_BYTES-3 (0x3FD) -> mem_ce never 1, wb_fault=1, wb_reg_write=0. LW at 0x3FC succeeds.
- ALU op ex_alu_result=0x1234, rd=5, reg_write=1 -> next cycle wb_data=00001234, wb_rd=5, wb_reg_write=1, mem_ce=0.
- SB issued, then rst=1 in the RMW cycle -> no write strobe; memory unchanged; all wb_* = 0; next SW completes normally.
